// File: rtl/pipe_stage_register.sv
// Single-entry pipeline stage with optional skid buffer and saturating stall counter.
// Define PIPE_STAGE_SKID_EN to add the skid register and fully registered ready_o.
module pipe_stage_register #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n_i,
  input  logic                  flush_i,
  input  logic                  valid_i,
  output logic                  ready_o,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic [CNT_WIDTH-1:0]  stall_cnt_o
);

  // Handshake: a payload moves across a boundary on a rising clk edge where
  // valid and ready are both high; once valid_o is raised it and data_o stay
  // put until ready_i is seen high at an edge (or flush/reset removes them).
  logic                  main_valid;
  logic [DATA_WIDTH-1:0] main_data;
  logic                  in_xfer;
  logic                  out_xfer;
  logic                  stall;

  assign in_xfer  = valid_i & ready_o;
  assign out_xfer = main_valid & ready_i;
  assign stall    = main_valid & ~ready_i;

  assign valid_o = main_valid;
  assign data_o  = main_data;

  // Counts on pre-flush state, so a flushed stall cycle is still counted.
  always_ff @(posedge clk or negedge rst_n_i) begin
    if (!rst_n_i) begin
      stall_cnt_o <= '0;
    end else if (stall && (stall_cnt_o != {CNT_WIDTH{1'b1}})) begin
      stall_cnt_o <= stall_cnt_o + CNT_WIDTH'(1);
    end
  end

`ifdef PIPE_STAGE_SKID_EN
  logic                  skid_valid;
  logic [DATA_WIDTH-1:0] skid_data;

  // skid_valid is a flop, so ready_o has no path from ready_i.
  assign ready_o = ~skid_valid;

  always_ff @(posedge clk or negedge rst_n_i) begin
    if (!rst_n_i) begin
      main_valid <= 1'b0;
      main_data  <= '0;
      skid_valid <= 1'b0;
      skid_data  <= '0;
    end else if (flush_i) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else if (!main_valid || out_xfer) begin
      // Main is free this cycle: the older skid entry goes first. A full skid
      // implies ready_o=0, so no input can arrive in the same cycle.
      if (skid_valid) begin
        main_data  <= skid_data;
        main_valid <= 1'b1;
        skid_valid <= 1'b0;
      end else if (in_xfer) begin
        main_data  <= data_i;
        main_valid <= 1'b1;
      end else begin
        main_valid <= 1'b0;
      end
    end else if (in_xfer) begin
      skid_data  <= data_i;
      skid_valid <= 1'b1;
    end
  end
`else
  assign ready_o = ~main_valid | ready_i;

  always_ff @(posedge clk or negedge rst_n_i) begin
    if (!rst_n_i) begin
      main_valid <= 1'b0;
      main_data  <= '0;
    end else if (flush_i) begin
      main_valid <= 1'b0;
    end else if (in_xfer) begin
      main_data  <= data_i;
      main_valid <= 1'b1;
    end else if (out_xfer) begin
      main_valid <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_stage_register.sv
// Self-checking bench for pipe_stage_register: vector table, corner sequences,
// and a long random run against a queue-based model of the stage.
module tb_pipe_stage_register;
  localparam int DW = 32;
  localparam int CW = 16;
`ifdef PIPE_STAGE_SKID_EN
  localparam int CAPACITY = 2;
`else
  localparam int CAPACITY = 1;
`endif

  logic          clk;
  logic          rst_n;
  logic          flush;
  logic          valid_in;
  logic          ready_in;
  logic [DW-1:0] data_in;
  logic          ready_out;
  logic          valid_out;
  logic [DW-1:0] data_out;
  logic [CW-1:0] stall_cnt;
  logic          small_ready;
  logic          small_valid;
  logic [7:0]    small_data;
  logic [1:0]    small_stall;

  int total;
  int bad;

  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] got_q[$];
  logic [DW-1:0] last_shown;
  int            stall_m;

  typedef struct packed {
    logic          flush;
    logic          valid;
    logic [DW-1:0] data;
    logic          ready;
    logic          exp_valid;
    logic [DW-1:0] exp_data;
    logic [CW-1:0] exp_stall;
  } vec_t;
  vec_t vecs[12];

  pipe_stage_register #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst_n_i(rst_n), .flush_i(flush), .valid_i(valid_in),
    .ready_o(ready_out), .data_i(data_in), .valid_o(valid_out),
    .ready_i(ready_in), .data_o(data_out), .stall_cnt_o(stall_cnt)
  );

  pipe_stage_register #(.DATA_WIDTH(8), .CNT_WIDTH(2)) dut_small (
    .clk(clk), .rst_n_i(rst_n), .flush_i(flush), .valid_i(valid_in),
    .ready_o(small_ready), .data_i(data_in[7:0]), .valid_o(small_valid),
    .ready_i(ready_in), .data_o(small_data), .stall_cnt_o(small_stall)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic f, input logic v, input logic [DW-1:0] d, input logic r);
    flush    = f;
    valid_in = v;
    data_in  = d;
    ready_in = r;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive(1'b0, 1'b0, '0, 1'b0);
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
    tick();
    exp_q.delete();
    last_shown = '0;
    stall_m = 0;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    drive(1'b0, 1'b1, 32'h1234_5678, 1'b1);
    tick();
    check("reset_valid", valid_out, 0);
    check("reset_data", data_out, 0);
    check("reset_stall", stall_cnt, 0);
    check("reset_ready", ready_out, 1);
    #3;
    rst_n = 1'b1;
    #1;
    check("release_ready", ready_out, 1);
    tick();

    // vector table
    vecs[0]  = '{1'b0, 1'b1, 32'hA5A5A5A5, 1'b1, 1'b1, 32'hA5A5A5A5, 16'd0};
    vecs[1]  = '{1'b0, 1'b1, 32'h11,       1'b1, 1'b1, 32'h11,       16'd0};
    vecs[2]  = '{1'b0, 1'b0, 32'h99,       1'b1, 1'b0, 32'h11,       16'd0};
    vecs[3]  = '{1'b0, 1'b0, 32'h98,       1'b1, 1'b0, 32'h11,       16'd0};
    vecs[4]  = '{1'b0, 1'b1, 32'h22,       1'b0, 1'b1, 32'h22,       16'd0};
    vecs[5]  = '{1'b0, 1'b0, 32'h97,       1'b0, 1'b1, 32'h22,       16'd1};
    vecs[6]  = '{1'b0, 1'b0, 32'h96,       1'b0, 1'b1, 32'h22,       16'd2};
    vecs[7]  = '{1'b0, 1'b0, 32'h95,       1'b1, 1'b0, 32'h22,       16'd2};
    vecs[8]  = '{1'b1, 1'b1, 32'h33,       1'b1, 1'b0, 32'h22,       16'd2};
    vecs[9]  = '{1'b0, 1'b1, 32'h44,       1'b0, 1'b1, 32'h44,       16'd2};
    vecs[10] = '{1'b1, 1'b0, 32'h94,       1'b0, 1'b0, 32'h44,       16'd3};
    vecs[11] = '{1'b0, 1'b1, 32'h55,       1'b1, 1'b1, 32'h55,       16'd3};
    do_reset();
    for (int i = 0; i < 12; i++) begin
      drive(vecs[i].flush, vecs[i].valid, vecs[i].data, vecs[i].ready);
      tick();
      check($sformatf("vec%0d_valid", i), valid_out, vecs[i].exp_valid);
      check($sformatf("vec%0d_data", i), data_out, vecs[i].exp_data);
      check($sformatf("vec%0d_stall", i), stall_cnt, vecs[i].exp_stall);
    end

    // stalled output: counter, hold, saturation on the narrow counter
    do_reset();
    drive(1'b0, 1'b1, 32'h77, 1'b1);
    tick();
    drive(1'b0, 1'b0, 32'hFF, 1'b0);
    check("stall_load_valid", valid_out, 1);
    check("stall_load_data", data_out, 32'h77);
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("stall_hold%0d_data", i), data_out, 32'h77);
      check($sformatf("stall_hold%0d_valid", i), valid_out, 1);
    end
    check("stall_cnt5", stall_cnt, 5);
    tick();
    check("stall_cnt6", stall_cnt, 6);
    check("small_stall_sat", small_stall, 3);
    check("small_data", small_data, 8'h77);

    // flush with the stage full and an input offered
    do_reset();
    drive(1'b0, 1'b1, 32'h1, 1'b0);
    tick();
    drive(1'b0, 1'b1, 32'h2, 1'b0);
    tick();
    check("full_ready", ready_out, 0);
    check("full_stall", stall_cnt, 1);
    drive(1'b1, 1'b1, 32'h3, 1'b1);
    tick();
    drive(1'b0, 1'b0, 32'h0, 1'b1);
    check("flush_valid", valid_out, 0);
    check("flush_ready", ready_out, 1);
    check("flush_stall", stall_cnt, 1);
    check("flush_data_kept", data_out, 32'h1);
    tick();
    check("flush_input_dropped", valid_out, 0);

`ifdef PIPE_STAGE_SKID_EN
    // skid fill then drain in order
    do_reset();
    drive(1'b0, 1'b1, 32'h1, 1'b1);
    tick();
    drive(1'b0, 1'b1, 32'h2, 1'b0);
    tick();
    check("skid_ready_low", ready_out, 0);
    drive(1'b0, 1'b1, 32'h3, 1'b0);
    tick();
    check("skid_held_ready", ready_out, 0);
    check("skid_head_data", data_out, 32'h1);
    ready_in = 1'b1;
    got_q.delete();
    for (int i = 0; i < 8; i++) begin
      logic accepted;
      @(negedge clk);
      accepted = valid_in && ready_out;
      if (valid_out && ready_in) got_q.push_back(data_out);
      tick();
      if (accepted) valid_in = 1'b0;
    end
    check("skid_out_count", got_q.size(), 3);
    for (int i = 0; i < 3 && i < got_q.size(); i++)
      check($sformatf("skid_out%0d", i), got_q[i], i + 1);
`endif

    // asynchronous reset between edges
    do_reset();
    drive(1'b0, 1'b1, 32'hDEADBEEF, 1'b0);
    tick();
    drive(1'b0, 1'b0, 32'h0, 1'b0);
    check("async_pre_valid", valid_out, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_valid", valid_out, 0);
    check("async_data", data_out, 0);
    check("async_stall", stall_cnt, 0);
    check("async_ready", ready_out, 1);
    #1;
    rst_n = 1'b1;
    tick();

    // random traffic against the queue model
    do_reset();
    for (int c = 0; c < 10000; c++) begin
      logic          e_valid;
      logic          e_ready;
      logic [DW-1:0] e_data;
      int            pct;
      pct = ((c / 1000) % 2 == 1) ? 30 : 80;
      drive(($urandom_range(0, 31) == 0), $urandom_range(0, 1), $urandom,
            ($urandom_range(0, 99) < pct));
      @(negedge clk);
      e_valid = (exp_q.size() > 0);
      e_data  = e_valid ? exp_q[0] : last_shown;
      e_ready = (CAPACITY == 2) ? (exp_q.size() < 2) : (!e_valid || ready_in);
      check("rnd_valid", valid_out, e_valid);
      check("rnd_data", data_out, e_data);
      check("rnd_ready", ready_out, e_ready);
      check("rnd_stall", stall_cnt, stall_m);
      if (e_valid && !ready_in && stall_m < (1 << CW) - 1) stall_m++;
      if (flush) begin
        exp_q.delete();
      end else begin
        if (e_valid && ready_in) void'(exp_q.pop_front());
        if (valid_in && e_ready) exp_q.push_back(data_in);
      end
      if (exp_q.size() > 0) last_shown = exp_q[0];
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipe_stage_register.md
PIPE_STAGE_REGISTER -- requirements
Module: pipe_stage_register

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: payload width in bits, minimum 1.
REQ-002 SHALL have parameter CNT_WIDTH, default 16: stall counter width in bits, minimum 1.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n_i  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port flush_i  input  1  synchronous pipeline flush.
REQ-006 SHALL have port valid_i  input  1  upstream payload valid.
REQ-007 SHALL have port ready_o  output  1  stage can accept a payload.
REQ-008 SHALL have port data_i  input  DATA_WIDTH  upstream payload.
REQ-009 SHALL have port valid_o  output  1  downstream payload valid.
REQ-010 SHALL have port ready_i  input  1  downstream accepts the payload.
REQ-011 SHALL have port data_o  output  DATA_WIDTH  downstream payload.
REQ-012 SHALL have port stall_cnt_o  output  CNT_WIDTH  count of stalled-output cycles.

Function
REQ-013 SHALL define input transfer as valid_i && ready_o and output transfer as valid_o && ready_i, both sampled at the rising edge of clk.
REQ-014 SHALL hold data in a main register, which drives data_o and valid_o, and in a skid register.
REQ-015 SHALL deliver a payload accepted into an empty stage on valid_o/data_o the following cycle, giving 1-cycle latency.
REQ-016 SHALL load an accepted payload into the main register when the main register is empty or is draining in that cycle; otherwise it SHALL load the payload into the skid register.
REQ-017 SHALL move skid contents to the main register and mark the skid register empty when the main register drains while the skid register is full.
REQ-018 SHALL preserve strict FIFO order, with no loss and no duplication, under any valid_i/ready_i pattern.
REQ-019 SHALL keep data_o and valid_o stable while valid_o=1 and ready_i=0.
REQ-020 SHALL hold the last loaded value on data_o when no load occurs, including while valid_o=0.
REQ-021 SHALL, when flush_i=1, clear the main and skid valid bits at the next edge, discard any input transfer in that cycle, and leave data registers unchanged; flush overrides all simultaneous events.
REQ-022 SHALL increment stall_cnt_o in every cycle with valid_o=1 and ready_i=0, evaluated on pre-flush state, saturating at all-ones; flush SHALL NOT clear it.
REQ-023 SHALL allow ready_o to depend combinationally on ready_i only where the Configuration section permits it.

Reset
REQ-024 SHALL, while rst_n_i=0, immediately force valid_o=0, skid valid=0, data_o=0, skid data=0 and stall_cnt_o=0, independent of clk.
REQ-025 SHALL drive ready_o=1 during reset and in the first cycle after deassertion.
REQ-026 SHALL discard in-flight payloads when reset asserts mid-transfer, with no partial update.

Configuration
REQ-027 SHALL compile the skid register in when macro PIPE_STAGE_SKID_EN is defined: ready_o = NOT skid_valid, registered, with no combinational path from ready_i.
REQ-028 SHALL, without PIPE_STAGE_SKID_EN, omit the skid register and drive ready_o = NOT valid_o OR ready_i (combinational); REQ-016/017 then reduce to main-register load on acceptance.
REQ-029 SHALL behave identically at the port level under both macro settings except for ready_o timing.

Verification
REQ-030 SHALL cover: reset release, valid_i=1, data_i=0xA5A5A5A5, ready_i=1 -> valid_o=1, data_o=0xA5A5A5A5 one cycle later, stall_cnt_o=0.
REQ-031 SHALL cover (SKID_EN): stream 0x1,0x2,0x3 with ready_i=0 from cycle 2 -> ready_o=0 after 0x2 is skidded, 0x3 held upstream; ready_i=1 -> outputs 0x1,0x2,0x3 in order.
REQ-032 SHALL cover: valid_o=1, ready_i=0 for 5 cycles -> stall_cnt_o=5, data_o constant; with CNT_WIDTH=2, 6 stall cycles -> stall_cnt_o=3.
REQ-033 SHALL cover: flush_i=1 with main and skid full and valid_i=1 -> next cycle valid_o=0, ready_o=1, input dropped, stall_cnt_o unchanged.
REQ-034 SHALL cover: rst_n_i pulsed low mid-cycle while valid_o=1 -> valid_o=0, data_o=0 immediately, before the next clk edge.
REQ-035 SHALL cover: random valid_i/ready_i for 10000 cycles, both macro settings -> output sequence equals input sequence against a scoreboard.
